// File: rtl/gray_cnt_rx_if.sv
`default_nettype none
// ============================================================================
// gray_cnt_rx_if : Gray-count link between a Gray counter (master) and its
//                  receiver/checker (slave).  Rev 1.0
// Optional macro GRAY_CNT_RX_ERRCNT_EN adds the 8-bit err_cnt signal.
// ============================================================================
interface gray_cnt_rx_if #(
   parameter int W = 3
);
   logic [W-1:0] g;
   logic [W-1:0] bin;
   logic         upd;
   logic         dir;
   logic         wrap;
   logic         err;
`ifdef GRAY_CNT_RX_ERRCNT_EN
   logic [7:0]   err_cnt;

   modport master (output g, input bin, upd, dir, wrap, err, err_cnt);
   modport slave  (input g, output bin, upd, dir, wrap, err, err_cnt);
`else
   modport master (output g, input bin, upd, dir, wrap, err);
   modport slave  (input g, output bin, upd, dir, wrap, err);
`endif
endinterface
`default_nettype wire

// File: rtl/gray_cnt_rx.sv
`default_nettype none
// ============================================================================
// gray_cnt_rx : Gray-count receiver - two-flop sync, Gray->binary decode,
//               step/direction/wrap reporting and illegal-step detection.
// Optional macro GRAY_CNT_RX_ERRCNT_EN adds a saturating illegal-step counter.
// Rev 1.0
// ============================================================================
module gray_cnt_rx #(
   parameter int W = 3
) (
   input  logic             ck,
   input  logic             res,
   gray_cnt_rx_if.slave     bus
);

   localparam logic [W-1:0] c_one = W'(1);
   localparam logic [W-1:0] c_max = {W{1'b1}};

   typedef enum logic [1:0] {
      FILL0 = 2'd0,
      FILL1 = 2'd1,
      LOCK  = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t       state_q;
   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;
   logic [W-1:0] prev_q;
   logic [W-1:0] bin_q;
   logic         upd_q;
   logic         dir_q;
   logic         wrap_q;
   logic         err_q;
`ifdef GRAY_CNT_RX_ERRCNT_EN
   logic [7:0]   err_cnt_q;
`endif

   logic [W-1:0] w_b;
   logic [W-1:0] w_diff;
   logic         w_single;
   logic         w_up;
   logic         w_wrap;

   always_comb begin
      w_b        = '0;
      w_b[W-1]   = s2_q[W-1];
      for (int i = W - 2; i >= 0; i--) begin
         w_b[i] = w_b[i+1] ^ s2_q[i];
      end
   end

   // A legal Gray step flips exactly one bit: nonzero and a power of two.
   assign w_diff   = s2_q ^ prev_q;
   assign w_single = (w_diff != '0) && ((w_diff & (w_diff - c_one)) == '0);
   assign w_up     = (w_b == (bin_q + c_one));
   assign w_wrap   = w_up ? (bin_q == c_max) : (bin_q == '0);

   always_ff @(posedge ck or negedge res) begin
      if (!res) begin
         state_q   <= FILL0;
         s1_q      <= '0;
         s2_q      <= '0;
         prev_q    <= '0;
         bin_q     <= '0;
         upd_q     <= 1'b0;
         dir_q     <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef GRAY_CNT_RX_ERRCNT_EN
         err_cnt_q <= 8'd0;
`endif
      end else begin
         s1_q   <= bus.g;
         s2_q   <= s1_q;
         upd_q  <= 1'b0;
         wrap_q <= 1'b0;
         case (state_q)
            FILL0: state_q <= FILL1;
            FILL1: state_q <= LOCK;
            LOCK: begin
               prev_q  <= s2_q;
               bin_q   <= w_b;
               state_q <= RUN;
            end
            RUN: begin
               if (s2_q != prev_q) begin
                  prev_q <= s2_q;
                  bin_q  <= w_b;
                  upd_q  <= 1'b1;
                  if (w_single) begin
                     dir_q  <= w_up;
                     wrap_q <= w_wrap;
                  end else begin
                     err_q <= 1'b1;
`ifdef GRAY_CNT_RX_ERRCNT_EN
                     if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                     end
`endif
                  end
               end
            end
            default: state_q <= FILL0;
         endcase
      end
   end

   assign bus.bin  = bin_q;
   assign bus.upd  = upd_q;
   assign bus.dir  = dir_q;
   assign bus.wrap = wrap_q;
   assign bus.err  = err_q;
`ifdef GRAY_CNT_RX_ERRCNT_EN
   assign bus.err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_cnt_rx.sv
`default_nettype none
// ============================================================================
// tb_gray_cnt_rx : directed self-checking bench for gray_cnt_rx (W = 3).
// Honours GRAY_CNT_RX_ERRCNT_EN when the design is built with it.  Rev 1.0
// ============================================================================
module tb_gray_cnt_rx;

   logic ck = 1'b0;
   logic res;
   int   pass_cnt  = 0;
   int   fail_cnt  = 0;
   int   total     = 0;
   int   upd_seen  = 0;
   int   wrap_seen = 0;
   logic [2:0] up_seq [8];

   gray_cnt_rx_if #(.W(3)) bus ();

   gray_cnt_rx #(.W(3)) dut (
      .ck  (ck),
      .res (res),
      .bus (bus)
   );

   always #5 ck = ~ck;

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one Gray value and expect its decoded step three edges later.
   task automatic step3(input string tag, input logic [2:0] gv, input logic [2:0] pb,
                        input logic [2:0] eb, input logic ed, input logic ew);
      bus.g = gv;
      tick();
      tick();
      check({tag, "_lat_upd"}, bus.upd, 0);
      check({tag, "_lat_bin"}, bus.bin, pb);
      tick();
      check({tag, "_upd"},  bus.upd,  1);
      check({tag, "_bin"},  bus.bin,  eb);
      check({tag, "_dir"},  bus.dir,  ed);
      check({tag, "_wrap"}, bus.wrap, ew);
   endtask

   initial begin
      up_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

      res   = 1'b0;
      bus.g = 3'b000;
      tick();
      check("rst_bin",  bus.bin,  0);
      check("rst_upd",  bus.upd,  0);
      check("rst_dir",  bus.dir,  0);
      check("rst_wrap", bus.wrap, 0);
      check("rst_err",  bus.err,  0);
`ifdef GRAY_CNT_RX_ERRCNT_EN
      check("rst_errcnt", bus.err_cnt, 0);
`endif
      res = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("lock_upd",  bus.upd,  0);
         check("lock_wrap", bus.wrap, 0);
      end
      check("lock_bin", bus.bin, 0);
      check("lock_err", bus.err, 0);

      // Up count with a Gray step every two cycles.
      for (int i = 0; i < 8; i++) begin
         bus.g = up_seq[i];
         tick();
         if (i > 0) begin
            check("up_upd",  bus.upd,  1);
            check("up_bin",  bus.bin,  i);
            check("up_dir",  bus.dir,  1);
            check("up_wrap", bus.wrap, 0);
         end
         upd_seen  += int'(bus.upd);
         wrap_seen += int'(bus.wrap);
         tick();
         check("up_lat_upd", bus.upd, 0);
         check("up_lat_bin", bus.bin, i);
         upd_seen  += int'(bus.upd);
         wrap_seen += int'(bus.wrap);
      end
      tick();
      check("upwrap_upd",  bus.upd,  1);
      check("upwrap_bin",  bus.bin,  0);
      check("upwrap_dir",  bus.dir,  1);
      check("upwrap_wrap", bus.wrap, 1);
      upd_seen  += int'(bus.upd);
      wrap_seen += int'(bus.wrap);
      tick();
      check("upend_upd",  bus.upd,  0);
      check("upend_wrap", bus.wrap, 0);
      upd_seen  += int'(bus.upd);
      wrap_seen += int'(bus.wrap);
      check("up_upd_count",  upd_seen,  8);
      check("up_wrap_count", wrap_seen, 1);
      check("up_err",        bus.err,   0);

      step3("dn1",  3'b100, 3'd0, 3'd7, 1'b0, 1'b1);
      step3("dn2",  3'b101, 3'd7, 3'd6, 1'b0, 1'b0);
      step3("ub1",  3'b100, 3'd6, 3'd7, 1'b1, 1'b0);
      step3("ub2",  3'b000, 3'd7, 3'd0, 1'b1, 1'b1);

      // Consecutive-cycle steps 000 -> 001 -> 011.
      bus.g = 3'b001;
      tick();
      bus.g = 3'b011;
      tick();
      tick();
      check("b2b_upd1", bus.upd, 1);
      check("b2b_bin1", bus.bin, 1);
      tick();
      check("b2b_upd2", bus.upd, 1);
      check("b2b_bin2", bus.bin, 2);
      check("b2b_dir2", bus.dir, 1);
      tick();
      check("b2b_upd3", bus.upd, 0);

      step3("dn3", 3'b001, 3'd2, 3'd1, 1'b0, 1'b0);
      step3("dn4", 3'b000, 3'd1, 3'd0, 1'b0, 1'b0);
      step3("up1", 3'b001, 3'd0, 3'd1, 1'b1, 1'b0);

      // Illegal two-bit jump 001 -> 111: dir must hold its previous 1.
      bus.g = 3'b111;
      tick();
      tick();
      check("ill_lat_err", bus.err, 0);
      tick();
      check("ill_bin",  bus.bin,  5);
      check("ill_upd",  bus.upd,  1);
      check("ill_err",  bus.err,  1);
      check("ill_dir",  bus.dir,  1);
      check("ill_wrap", bus.wrap, 0);
`ifdef GRAY_CNT_RX_ERRCNT_EN
      check("ill_errcnt", bus.err_cnt, 1);
`endif
      step3("post1", 3'b101, 3'd5, 3'd6, 1'b1, 1'b0);
      check("post1_err", bus.err, 1);
      step3("post2", 3'b111, 3'd6, 3'd5, 1'b0, 1'b0);
      check("post2_err", bus.err, 1);
`ifdef GRAY_CNT_RX_ERRCNT_EN
      check("post_errcnt", bus.err_cnt, 1);
      for (int i = 0; i < 10; i++) begin
         bus.g = (i % 2 == 0) ? 3'b001 : 3'b111;
         tick();
      end
      check("errcnt_mid", bus.err_cnt, 9);
      for (int i = 10; i < 300; i++) begin
         bus.g = (i % 2 == 0) ? 3'b001 : 3'b111;
         tick();
      end
      tick();
      tick();
      tick();
      check("errcnt_sat", bus.err_cnt, 255);
      check("errcnt_bin", bus.bin, 5);
      check("errcnt_err", bus.err, 1);
`endif

      // Reset between edges while an update pulse is high and bin = 5.
      step3("prerst", 3'b101, 3'd5, 3'd6, 1'b1, 1'b0);
      bus.g = 3'b111;
      tick();
      tick();
      tick();
      check("prerst_bin", bus.bin, 5);
      check("prerst_upd", bus.upd, 1);
      #3;
      res = 1'b0;
      #1;
      check("mid_rst_bin", bus.bin, 0);
      check("mid_rst_upd", bus.upd, 0);
      check("mid_rst_err", bus.err, 0);
      check("mid_rst_dir", bus.dir, 0);
`ifdef GRAY_CNT_RX_ERRCNT_EN
      check("mid_rst_errcnt", bus.err_cnt, 0);
`endif
      tick();
      res = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("relock_fill_upd", bus.upd, 0);
         check("relock_fill_bin", bus.bin, 0);
      end
      tick();
      check("relock_bin",  bus.bin,  5);
      check("relock_upd",  bus.upd,  0);
      check("relock_wrap", bus.wrap, 0);
      check("relock_err",  bus.err,  0);
      tick();
      check("relock_hold_upd", bus.upd, 0);
      check("relock_hold_bin", bus.bin, 5);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
`default_nettype wire
